prbs5_checker: RTL and testbench
================================

PRBS5_CHECKER -- requirements
Module: prbs5_checker

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock; all state changes on this edge.
REQ-003 rst_b  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-004 din  input  1  received serial bit, sampled when din_vld=1.
REQ-005 din_vld  input  1  qualifies din; when 0, no state changes except reset and clr_cnt.
REQ-006 clr_cnt  input  1  synchronous clear of err_cnt.
REQ-007 locked  output  1  registered; 1 while in CHECK state.
REQ-008 err  output  1  registered one-cycle pulse per mismatched bit.
REQ-009 err_cnt  output  8  registered saturating mismatch counter.
REQ-010 state  output  2  FSM state encoding: 00 HUNT, 01 CHECK.

Function
REQ-011 SHALL check a stream obeying s[n] = s[n-3] XOR s[n-5]. This is the output bit q[4] of the lab 5-bit Galois LFSR with d0=q4, d2=q4^q1, other stages shifting, seeded 11111. Its first bits are 1,1,1,0,0,0,1,1,0,1,1.
REQ-012 SHALL keep a 5-bit history h[4:0]; h[0] is the most recent accepted bit. On each valid bit, h shifts left and din enters h[0].
REQ-013 The history SHALL always shift in the received din, not the predicted bit, so the checker is self-synchronizing.
REQ-014 HUNT: a 3-bit fill counter increments per valid bit. When the 5th bit is accepted, go to CHECK at that edge if the new h is nonzero.
REQ-015 HUNT: if the 5 accepted bits are all zero, stay in HUNT, reset the fill counter to 0 and raise no error (zero-lock guard).
REQ-016 CHECK: for each valid bit, predicted = h[2] XOR h[4] (pre-shift history). A mismatch with din is an error.
REQ-017 CHECK error: err=1 in the cycle after the edge that sampled the bit, err_cnt increments (saturating at 255) and a 2-bit consecutive-error count increments.
REQ-018 CHECK match: err=0 and the consecutive-error count clears.
REQ-019 On the 3rd consecutive error, go to HUNT at that edge. That error is still counted. Fill and consecutive counts clear; history is kept but ignored until refilled.
REQ-020 locked SHALL rise on the edge that accepts the 5th fill bit. The first checked bit is the 6th valid bit after HUNT entry.
REQ-021 din_vld=0: h, fill, FSM and err_cnt hold (except clr_cnt); err=0.
REQ-022 err SHALL never be asserted in HUNT.
REQ-023 clr_cnt=1: err_cnt=0 at the next edge. Clear wins over a simultaneous increment, and err still pulses for that error.
REQ-024 err_cnt SHALL hold at 255 on further errors and never wrap.
REQ-025 A single flipped bit at index n of a locked stream SHALL produce errors at n, n+3 and n+5, with no lock loss.

Reset
REQ-026 rst_b=0 at a clk edge: state=HUNT, h=00000, fill=0, consecutive=0, locked=0, err=0, err_cnt=0. This SHALL hold regardless of din_vld/clr_cnt and regardless of current state (mid-lock included).
REQ-027 After rst_b returns to 1, the first valid bit SHALL be fill bit 1.

Verification
REQ-028 Reset, then 40 clean valid bits (1,1,1,0,0,0,1,1,0,1,1,...) -> locked=1 after the 5th-bit edge, err never 1, err_cnt=0.
REQ-029 Clean stream with bit index 10 inverted (0-based) -> err pulses for bits 10, 13 and 15, err_cnt=3, locked stays 1.
REQ-030 Clean stream with bits 12, 13 and 14 inverted -> 3 consecutive err pulses and locked=0 after bit 14. Relock after bits 15-19, err_cnt=3 thereafter.
REQ-031 20 valid zero bits after reset -> locked stays 0, err_cnt=0, state=00.
REQ-032 Clean stream with din_vld=0 every other cycle and din random in gaps -> same locked/err_cnt results as REQ-028.
REQ-033 Locked with err_cnt=3 -> clr_cnt pulse gives err_cnt=0. Then rst_b=0 for one edge mid-stream -> locked=0 and err_cnt=0 on that edge, relock 5 valid bits after release.

Source files
------------

// File: rtl/prbs5_checker.sv
// Self-synchronizing PRBS5 (s[n] = s[n-3] ^ s[n-5]) receive checker with
// hunt/lock FSM, per-bit error pulse and saturating error counter.
module prbs5_checker (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       din,
  input  logic       din_vld,
  input  logic       clr_cnt,
  output logic       locked,
  output logic       err,
  output logic [7:0] err_cnt,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    HUNT  = 2'b00,
    CHECK = 2'b01
  } state_t;

  state_t     st;
  logic [4:0] h;
  logic [2:0] fill;
  logic [1:0] consec;

  logic [4:0] h_nxt;
  logic       mism;

  // History always takes the received bit, so a corrupted bit re-surfaces
  // as errors three and five bits later rather than derailing the lock.
  always_comb begin
    h_nxt = {h[3:0], din};
    mism  = din ^ (h[2] ^ h[4]);
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      st      <= HUNT;
      h       <= '0;
      fill    <= '0;
      consec  <= '0;
      locked  <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      err <= 1'b0;
      if (din_vld) begin
        h <= h_nxt;
        case (st)
          HUNT: begin
            if (fill == 3'd4) begin
              fill <= '0;
              if (h_nxt != '0) begin
                st     <= CHECK;
                locked <= 1'b1;
              end
            end else begin
              fill <= fill + 3'd1;
            end
          end
          CHECK: begin
            if (mism) begin
              err <= 1'b1;
              if (err_cnt != '1)
                err_cnt <= err_cnt + 8'd1;
              if (consec == 2'd2) begin
                st     <= HUNT;
                locked <= 1'b0;
                consec <= '0;
                fill   <= '0;
              end else begin
                consec <= consec + 2'd1;
              end
            end else begin
              consec <= '0;
            end
          end
          default: begin
            st     <= HUNT;
            locked <= 1'b0;
            fill   <= '0;
            consec <= '0;
          end
        endcase
      end
      // Clear takes priority over a same-edge increment.
      if (clr_cnt)
        err_cnt <= '0;
    end
  end

  assign state = st;

endmodule

// File: tb/tb_prbs5_checker.sv
// Scoreboard bench for prbs5_checker: a bit-level model pushes expected
// outputs per driven cycle; they are popped and compared after the edge.
module tb_prbs5_checker;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       din = 1'b0;
  logic       din_vld = 1'b0;
  logic       clr_cnt = 1'b0;
  logic       locked;
  logic       err;
  logic [7:0] err_cnt;
  logic [1:0] state;

  prbs5_checker dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .din     (din),
    .din_vld (din_vld),
    .clr_cnt (clr_cnt),
    .locked  (locked),
    .err     (err),
    .err_cnt (err_cnt),
    .state   (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       err;
    logic       locked;
    logic [7:0] cnt;
    logic [1:0] st;
  } exp_t;

  exp_t sbq[$];

  int checks = 0;
  int failures = 0;
  int nerr = 0;

  bit seq[0:1023];

  // model state
  int m_state = 0;
  int m_fill = 0;
  int m_consec = 0;
  int m_cnt = 0;
  bit m_locked = 1'b0;
  bit hq[$];

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit mpred();
    return hq[hq.size()-3] ^ hq[hq.size()-5];
  endfunction

  task automatic cyc(input bit d, input bit v, input bit clr, input bit rb);
    exp_t e;
    bit   mism;
    bit   nz;
    din = d; din_vld = v; clr_cnt = clr; rst_b = rb;
    e.err = 1'b0;
    if (!rb) begin
      m_state = 0; m_fill = 0; m_consec = 0; m_cnt = 0; m_locked = 1'b0;
      hq.delete();
    end else begin
      if (v) begin
        mism = 1'b0;
        if (m_state == 1) mism = (d != mpred());
        hq.push_back(d);
        if (hq.size() > 5) void'(hq.pop_front());
        if (m_state == 0) begin
          m_fill++;
          if (m_fill == 5) begin
            m_fill = 0;
            nz = 1'b0;
            foreach (hq[i]) nz |= hq[i];
            if (nz) begin m_state = 1; m_locked = 1'b1; end
          end
        end else if (mism) begin
          e.err = 1'b1;
          if (m_cnt < 255) m_cnt++;
          m_consec++;
          if (m_consec == 3) begin
            m_state = 0; m_locked = 1'b0; m_consec = 0; m_fill = 0;
          end
        end else begin
          m_consec = 0;
        end
      end
      if (clr) m_cnt = 0;
    end
    e.locked = m_locked;
    e.cnt    = 8'(m_cnt);
    e.st     = 2'(m_state);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("err", int'(err), int'(e.err));
    chk("locked", int'(locked), int'(e.locked));
    chk("err_cnt", int'(err_cnt), int'(e.cnt));
    chk("state", int'(state), int'(e.st));
    if (err) nerr++;
  endtask

  // Drive stream bits [first, first+n), inverting up to three chosen indices;
  // with gaps set, each bit is followed by an invalid cycle carrying random din.
  task automatic stream(input int first, input int n, input int f0, input int f1,
                        input int f2, input bit gaps);
    bit b;
    for (int i = first; i < first + n; i++) begin
      b = seq[i];
      if (i == f0 || i == f1 || i == f2) b = ~b;
      cyc(b, 1'b1, 1'b0, 1'b1);
      if (gaps) cyc(1'($urandom), 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic do_reset();
    cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
  endtask

  initial begin
    seq[0] = 1; seq[1] = 1; seq[2] = 1; seq[3] = 0; seq[4] = 0;
    for (int n = 5; n < 1024; n++) seq[n] = seq[n-3] ^ seq[n-5];

    // reset state, with random qualifiers
    for (int i = 0; i < 3; i++) do_reset();
    chk("rst_state", int'(state), 0);
    chk("rst_cnt", int'(err_cnt), 0);

    // clean stream: lock on the 5th bit, no errors
    nerr = 0;
    stream(0, 4, -1, -1, -1, 1'b0);
    chk("clean_pre_lock", int'(locked), 0);
    stream(4, 1, -1, -1, -1, 1'b0);
    chk("clean_lock5", int'(locked), 1);
    stream(5, 35, -1, -1, -1, 1'b0);
    chk("clean_nerr", nerr, 0);
    chk("clean_cnt", int'(err_cnt), 0);

    // single flipped bit: errors at 10, 13, 15, lock kept
    do_reset();
    nerr = 0;
    stream(0, 30, 10, -1, -1, 1'b0);
    chk("flip_nerr", nerr, 3);
    chk("flip_cnt", int'(err_cnt), 3);
    chk("flip_locked", int'(locked), 1);

    // clear, then mid-stream reset and relock
    cyc(1'($urandom), 1'b0, 1'b1, 1'b1);
    chk("clr_cnt", int'(err_cnt), 0);
    stream(30, 5, -1, -1, -1, 1'b0);
    cyc(seq[35], 1'b1, 1'b0, 1'b0);
    chk("midrst_locked", int'(locked), 0);
    chk("midrst_cnt", int'(err_cnt), 0);
    stream(36, 4, -1, -1, -1, 1'b0);
    chk("relock_pre", int'(locked), 0);
    stream(40, 1, -1, -1, -1, 1'b0);
    chk("relock", int'(locked), 1);
    nerr = 0;
    stream(41, 20, -1, -1, -1, 1'b0);
    chk("relock_nerr", nerr, 0);

    // three consecutive errors: lose lock, relock after five bits
    do_reset();
    nerr = 0;
    stream(0, 15, 12, 13, 14, 1'b0);
    chk("burst_unlock", int'(locked), 0);
    chk("burst_nerr", nerr, 3);
    stream(15, 5, -1, -1, -1, 1'b0);
    chk("burst_relock", int'(locked), 1);
    stream(20, 20, -1, -1, -1, 1'b0);
    chk("burst_cnt", int'(err_cnt), 3);

    // all-zero input never locks
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("zero_locked", int'(locked), 0);
    chk("zero_state", int'(state), 0);
    chk("zero_cnt", int'(err_cnt), 0);

    // gapped valid with random din in the gaps
    do_reset();
    nerr = 0;
    stream(0, 40, -1, -1, -1, 1'b1);
    chk("gap_locked", int'(locked), 1);
    chk("gap_cnt", int'(err_cnt), 0);
    chk("gap_nerr", nerr, 0);

    // alternating errors: never three in a row, clear collides with an error,
    // then the counter saturates
    for (int k = 0; k < 820; k++)
      cyc(mpred() ^ (k % 2 == 0), 1'b1, k == 300, 1'b1);
    chk("sat_cnt", int'(err_cnt), 255);
    chk("sat_locked", int'(locked), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
